// File: rtl/iddmm_pkg.sv
// Shared IDDMM definitions: engine word/result sizes and the arbiter FSM encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package iddmm_pkg;

  // Default engine geometry used across the IDDMM blocks.
  localparam int K_DEF = 256;
  localparam int N_DEF = 16;

  // Arbiter sequencing: pick a winner, start the engine, stream results, enforce a low gap.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request bit searching upward from ptr+1 modulo M.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is taken.
module rr_arbiter #(
  parameter int M    = 4,
  parameter int ID_W = (M > 1) ? $clog2(M) : 1
) (
  input  logic [M-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [M-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  logic [ID_W-1:0] pos;
  logic            found;

  assign any = |req;

  // Walk the M candidate positions in priority order; the first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 1; i <= M; i++) begin
      pos = ID_W'((int'(ptr) + i) % M);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/iddmm_arbiter.sv
// Shares one IDDMM engine among M requesters, round-robin, one task in flight at a time.
// Latency: req_valid->req_ready 1 cycle, req_ready->mm_task_req 1 cycle, engine word->rsp 1 cycle.
// Backpressure: requesters hold req_valid until granted; result stream cannot be stalled.
module iddmm_arbiter
  import iddmm_pkg::*;
#(
  parameter int K       = K_DEF,
  parameter int N       = N_DEF,
  parameter int M       = 4,
  parameter int ID_W    = (M > 1) ? $clog2(M) : 1,
  parameter int GAP_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [M-1:0]    req_valid,
  output logic [M-1:0]    req_ready,
  output logic [M-1:0]    rsp_valid,
  output logic [K-1:0]    rsp_data,
  output logic            rsp_last,
  output logic            rsp_err,
  output logic            busy,
  output logic [ID_W-1:0] mm_sel,
  output logic            mm_task_req,
  input  logic            mm_task_grant,
  input  logic [K-1:0]    mm_task_res,
  input  logic            mm_task_end
);

  localparam int CW = $clog2(N + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, ptr_nxt;
  logic [CW-1:0]   wcnt, wcnt_nxt, wcnt_inc, wcnt_total;
  logic            ovf, ovf_nxt;
  logic [GW-1:0]   gcnt, gcnt_nxt;

  logic [M-1:0]    ready_nxt, vld_nxt;
  logic [K-1:0]    data_nxt;
  logic            last_nxt, err_nxt, busy_nxt, task_req_nxt;
  logic [ID_W-1:0] sel_nxt;

  logic [M-1:0]    arb_grant;
  logic [ID_W-1:0] arb_idx;
  logic            arb_any;
  logic [M-1:0]    sel_onehot;

  rr_arbiter #(
    .M    (M),
    .ID_W (ID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign sel_onehot = M'(1) << mm_sel;
  // Word count saturates at N; anything beyond N is remembered in ovf so it still errors.
  assign wcnt_inc   = (wcnt == CW'(N)) ? wcnt : wcnt + CW'(1);
  assign wcnt_total = mm_task_grant ? wcnt_inc : wcnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and next values of every registered output/counter.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    sel_nxt      = mm_sel;
    ready_nxt    = '0;
    busy_nxt     = busy;
    task_req_nxt = mm_task_req;
    vld_nxt      = '0;
    data_nxt     = rsp_data;
    last_nxt     = 1'b0;
    err_nxt      = 1'b0;
    wcnt_nxt     = wcnt;
    ovf_nxt      = ovf;
    gcnt_nxt     = gcnt;
    case (state)
      IDLE: begin
        busy_nxt     = 1'b0;
        task_req_nxt = 1'b0;
        if (arb_any) begin
          ready_nxt = arb_grant;
          sel_nxt   = arb_idx;
          ptr_nxt   = arb_idx;
          busy_nxt  = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        task_req_nxt = 1'b1;
        wcnt_nxt     = '0;
        ovf_nxt      = 1'b0;
        state_nxt    = RUN;
      end
      RUN: begin
        if (mm_task_grant) begin
          vld_nxt  = sel_onehot;
          data_nxt = mm_task_res;
          wcnt_nxt = wcnt_inc;
          if (wcnt == CW'(N)) ovf_nxt = 1'b1;
        end
        if (mm_task_end) begin
          last_nxt     = 1'b1;
          err_nxt      = ovf || (mm_task_grant && (wcnt == CW'(N))) || (wcnt_total != CW'(N));
          task_req_nxt = 1'b0;
          gcnt_nxt     = '0;
          state_nxt    = GAP;
        end
      end
      GAP: begin
        task_req_nxt = 1'b0;
        gcnt_nxt     = gcnt + GW'(1);
        if (gcnt == GW'(GAP_CYC - 1)) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output and counter registers; pointer starts at M-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= ID_W'(M - 1);
      mm_sel      <= '0;
      req_ready   <= '0;
      busy        <= 1'b0;
      mm_task_req <= 1'b0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_last    <= 1'b0;
      rsp_err     <= 1'b0;
      wcnt        <= '0;
      ovf         <= 1'b0;
      gcnt        <= '0;
    end else begin
      ptr         <= ptr_nxt;
      mm_sel      <= sel_nxt;
      req_ready   <= ready_nxt;
      busy        <= busy_nxt;
      mm_task_req <= task_req_nxt;
      rsp_valid   <= vld_nxt;
      rsp_data    <= data_nxt;
      rsp_last    <= last_nxt;
      rsp_err     <= err_nxt;
      wcnt        <= wcnt_nxt;
      ovf         <= ovf_nxt;
      gcnt        <= gcnt_nxt;
    end
  end

endmodule

// File: tb/tb_iddmm_arbiter.sv
// Directed bench for iddmm_arbiter: grant order, result routing, word-count errors, reset.
// Latency: checks the fixed 1-cycle grant, start and word-forward delays.
// Backpressure: engine model streams words back-to-back once mm_task_req is seen.
module tb_iddmm_arbiter;

  localparam int K       = 256;
  localparam int N       = 16;
  localparam int M       = 4;
  localparam int ID_W    = 2;
  localparam int GAP_CYC = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [M-1:0]    req_valid;
  logic [M-1:0]    req_ready;
  logic [M-1:0]    rsp_valid;
  logic [K-1:0]    rsp_data;
  logic            rsp_last;
  logic            rsp_err;
  logic            busy;
  logic [ID_W-1:0] mm_sel;
  logic            mm_task_req;
  logic            mm_task_grant;
  logic [K-1:0]    mm_task_res;
  logic            mm_task_end;

  iddmm_arbiter #(
    .K(K), .N(N), .M(M), .ID_W(ID_W), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_last      (rsp_last),
    .rsp_err       (rsp_err),
    .busy          (busy),
    .mm_sel        (mm_sel),
    .mm_task_req   (mm_task_req),
    .mm_task_grant (mm_task_grant),
    .mm_task_res   (mm_task_res),
    .mm_task_end   (mm_task_end)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  v;
    logic        last;
    logic        err;
    logic [31:0] d;
  } rsp_t;

  rsp_t       rq[$];
  logic [5:0] gq[$];

  // Record every result-side event and every grant, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if ((|rsp_valid) || rsp_last) rq.push_back({rsp_valid, rsp_last, rsp_err, rsp_data[31:0]});
      if (|req_ready) gq.push_back({mm_sel, req_ready});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic clear_engine;
    mm_task_grant = 1'b0;
    mm_task_end   = 1'b0;
    mm_task_res   = '0;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    req_valid = '0;
    clear_engine();
    tick();
    tick();
    rst_n = 1'b1;
    rq.delete();
    gq.delete();
    tick();
  endtask

  task automatic wait_idle;
    int t = 0;
    while (busy !== 1'b0 && t < 100) begin
      tick();
      t++;
    end
    check("wait_idle", busy, 0);
  endtask

  // Engine model: wait for the start request, then stream nw words tagged with tag.
  task automatic engine(input int nw, input bit eow, input int tag, input bit pulse2);
    int t = 0;
    while (mm_task_req !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    check("eng_req_wait", mm_task_req, 1);
    for (int w = 1; w <= nw; w++) begin
      mm_task_grant = 1'b1;
      mm_task_res   = K'(tag * 256 + w);
      mm_task_end   = eow && (w == nw);
      if (pulse2) req_valid[2] = (w == 5);
      tick();
    end
    if (!eow) begin
      mm_task_grant = 1'b0;
      mm_task_end   = 1'b1;
      tick();
    end
    clear_engine();
  endtask

  task automatic check_grant(input int idx);
    logic [5:0] g;
    logic [5:0] e;
    #1;
    e = {2'(idx), 4'(1 << idx)};
    if (gq.size() == 0) begin
      check("grant_missing", 0, 1);
    end else begin
      g = gq.pop_front();
      check($sformatf("grant_%0d", idx), 64'(g), 64'(e));
    end
  endtask

  task automatic check_rsp(input int nw, input bit eow, input int tag, input logic [3:0] oh);
    int exp_n;
    rsp_t g;
    rsp_t e;
    exp_n = nw + (eow ? 0 : 1);
    #1;
    check($sformatf("rsp_count_t%0d", tag), 64'(rq.size()), 64'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      if (rq.size() == 0) break;
      g      = rq.pop_front();
      e.v    = (i < nw) ? oh : 4'b0000;
      e.last = (i == exp_n - 1);
      e.err  = (i == exp_n - 1) && (nw != N);
      e.d    = (i < nw) ? 32'(tag * 256 + i + 1) : 32'd0;
      if (i >= nw) g.d = 32'd0;
      check($sformatf("rsp_t%0d_w%0d", tag, i), 64'(g), 64'(e));
    end
    rq.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    clear_engine();
    tick();
    tick();
    check("reset_outs", 64'({req_ready, rsp_valid, rsp_last, rsp_err, busy, mm_task_req, mm_sel}), 0);
    check("reset_data", 64'(|rsp_data), 0);
    rst_n = 1'b1;
    tick();

    // Single requester: exact grant/start timing, 16 words, gap.
    req_valid = 4'b0001;
    tick();
    check("t1_ready", 64'(req_ready), 64'h1);
    check("t1_sel", 64'(mm_sel), 0);
    check("t1_busy", busy, 1);
    check("t1_req_low", mm_task_req, 0);
    req_valid = '0;
    tick();
    check("t1_req_rise", mm_task_req, 1);
    check("t1_ready_pulse", 64'(req_ready), 0);
    engine(16, 1'b1, 0, 1'b0);
    check_grant(0);
    check_rsp(16, 1'b1, 0, 4'b0001);
    check("t1_gap0_req", mm_task_req, 0);
    check("t1_gap0_busy", busy, 1);
    tick();
    check("t1_gap1_req", mm_task_req, 0);
    check("t1_gap1_busy", busy, 1);
    tick();
    check("t1_idle_busy", busy, 0);

    // All four requesting: rotation 0,1,2,3,0,1.
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      engine(16, 1'b1, i + 1, 1'b0);
      if (i == 5) req_valid = '0;
      check_grant(i % 4);
      check_rsp(16, 1'b1, i + 1, 4'(1 << (i % 4)));
    end

    // Requesters 1 and 3, 1 re-requests right after each rsp_last: alternation.
    do_reset();
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = (i % 2 == 0) ? 1 : 3;
      engine(16, 1'b1, 10 + i, 1'b0);
      if (i == 3) req_valid = '0;
      check_grant(idx);
      check_rsp(16, 1'b1, 10 + i, 4'(1 << idx));
      if (idx == 1) begin
        req_valid[1] = 1'b0;
        tick();
        req_valid[1] = 1'b1;
      end
    end

    // Short task: 15 words then a bare end -> separate last with error; then a clean one.
    wait_idle();
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    engine(15, 1'b0, 20, 1'b0);
    check_grant(0);
    check_rsp(15, 1'b0, 20, 4'b0001);
    wait_idle();
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    engine(16, 1'b1, 21, 1'b0);
    check_grant(1);
    check_rsp(16, 1'b1, 21, 4'b0010);

    // Reset at word 7 clears every output at once; afterwards 0 beats 2.
    wait_idle();
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    begin
      int t = 0;
      while (mm_task_req !== 1'b1 && t < 50) begin
        tick();
        t++;
      end
    end
    for (int w = 1; w <= 7; w++) begin
      mm_task_grant = 1'b1;
      mm_task_res   = K'(30 * 256 + w);
      tick();
    end
    check("t5_pre_rst_vld", 64'(rsp_valid), 64'h1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_outs", 64'({req_ready, rsp_valid, rsp_last, rsp_err, busy, mm_task_req, mm_sel}), 0);
    check("t5_rst_data", 64'(|rsp_data), 0);
    clear_engine();
    tick();
    rst_n = 1'b1;
    rq.delete();
    gq.delete();
    req_valid = 4'b0101;
    tick();
    check("t5_ready0", 64'(req_ready), 64'h1);
    check_grant(0);
    req_valid = 4'b0100;
    engine(16, 1'b1, 31, 1'b0);
    check_rsp(16, 1'b1, 31, 4'b0001);
    tick();
    tick();
    tick();
    check_grant(2);
    req_valid = '0;
    engine(16, 1'b1, 32, 1'b0);
    check_rsp(16, 1'b1, 32, 4'b0100);

    // One-cycle pulse on 2 during RUN is ignored; engine words outside RUN are dropped.
    wait_idle();
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    engine(16, 1'b1, 40, 1'b1);
    check_grant(0);
    check_rsp(16, 1'b1, 40, 4'b0001);
    for (int c = 0; c < 8; c++) begin
      mm_task_grant = 1'b1;
      mm_task_res   = K'(c + 100);
      tick();
    end
    clear_engine();
    tick();
    tick();
    check("t6_no_spurious_grant", 64'(gq.size()), 0);
    check("t6_stray_words", 64'(rq.size()), 0);
    check("t6_idle", busy, 0);
    check("t6_req_low", mm_task_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
